// File: rtl/mult_pkg.sv
// Package: mult_pkg
// Shared constants and FSM state type for the multiplier issue controller.
//   WIDTH         default operand width (product is 2*WIDTH)
//   FIFO_DEPTH    default operand FIFO depth (power of 2, >= 2)
//   MULT_LATENCY  default edges from sampled mult_start to valid mult_s
//   state_t       sequencer states IDLE / ISSUE / WAIT / HOLD
package mult_pkg;

    localparam int unsigned WIDTH        = 32;
    localparam int unsigned FIFO_DEPTH   = 4;
    localparam int unsigned MULT_LATENCY = 18;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/mult_op_fifo.sv
// Module: mult_op_fifo
// Synchronous operand FIFO with show-ahead read (rdata is the head entry).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, wdata   write strobe and data; ignored while full
//   pop           read strobe; ignored while empty
//   rdata         head entry, valid while !empty
//   full, empty   occupancy flags
//   count         number of stored entries (0..DEPTH)
module mult_op_fifo #(
    parameter int unsigned DW    = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Storage needs no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mult_issue_ctrl.sv
// Module: mult_issue_ctrl
// Front-end sequencer for a serial signed multiplier. Buffers operand pairs in a FIFO,
// issues one operation at a time (start pulse + held operands), waits MULT_LATENCY edges,
// captures the result and presents it on a single-entry valid/ready output.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid/in_ready/in_a/in_b  operand input handshake (in_ready = !fifo full)
//   out_valid/out_ready/out_p    product output handshake
//   mult_start/mult_a/mult_b     multiplier issue interface
//   mult_s                       multiplier result, sampled only at the capture edge
//   busy                         sequencer active or operands queued
module mult_issue_ctrl #(
    parameter int unsigned WIDTH        = mult_pkg::WIDTH,
    parameter int unsigned FIFO_DEPTH   = mult_pkg::FIFO_DEPTH,
    parameter int unsigned MULT_LATENCY = mult_pkg::MULT_LATENCY
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 mult_start,
    output logic [WIDTH-1:0]     mult_a,
    output logic [WIDTH-1:0]     mult_b,
    input  logic [2*WIDTH-1:0]   mult_s,
    output logic                 busy
);

    import mult_pkg::*;

    localparam int unsigned CNT_W = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [AW:0]          fifo_count;
    logic [2*WIDTH-1:0]   fifo_rdata;
    logic                 push;
    logic                 issue;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign busy     = (state != IDLE) || (fifo_count != '0);

    // An issue pops the FIFO head; from HOLD it coincides with the output handshake.
    always_comb begin
        issue = 1'b0;
        case (state)
            IDLE:    issue = !fifo_empty && !out_valid;
            HOLD:    issue = out_valid && out_ready && !fifo_empty;
            default: issue = 1'b0;
        endcase
    end

    mult_op_fifo #(
        .DW    (2 * WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({in_a, in_b}),
        .pop   (issue),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_p      <= '0;
            mult_start <= 1'b0;
            mult_a     <= '0;
            mult_b     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        {mult_a, mult_b} <= fifo_rdata;
                        mult_start       <= 1'b1;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    mult_start <= 1'b0;
                    cnt        <= CNT_W'(MULT_LATENCY - 1);
                    state      <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        out_p     <= mult_s;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        if (issue) begin
                            {mult_a, mult_b} <= fifo_rdata;
                            mult_start       <= 1'b1;
                            state            <= ISSUE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
